// File: rtl/lockin_sweep_ctrl.sv
// Lock-in LO sweep sequencer: programs pinc/poff per point, settles, averages 2^L mixer samples, emits mean.
// Optional quadrature pass (poff +90 deg, second settle/integrate) when LOCKIN_SWEEP_QUAD_EN is defined.
module lockin_sweep_ctrl #(
    parameter int ACC_W    = 48,
    parameter int NPTS_W   = 12,
    parameter int SETTLE_W = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic        [23:0]         pinc_start_in,
    input  logic signed [23:0]         pinc_step_in,
    input  logic        [NPTS_W-1:0]   npts_in,
    input  logic        [SETTLE_W-1:0] settle_in,
    input  logic        [3:0]          log2_navg_in,
    input  logic signed [23:0]         poff_in,
    input  logic signed [31:0]         mix_in,
    output logic        [23:0]         pinc_out,
    output logic signed [23:0]         poff_out,
    output logic signed [31:0]         result_out,
    output logic signed [31:0]         result_q_out,
    output logic        [NPTS_W-1:0]   result_idx_out,
    output logic                       result_valid_out,
    input  logic                       result_ready_in,
    output logic                       busy_out,
    output logic                       done_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_INTEG,
`ifdef LOCKIN_SWEEP_QUAD_EN
        S_SETTLE_Q,
        S_INTEG_Q,
`endif
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [23:0]               pinc_q, pinc_d;
    logic [23:0]               poff_q, poff_d;
    logic [23:0]               step_q, step_d;
    logic [NPTS_W-1:0]         npts_q, npts_d;
    logic [NPTS_W-1:0]         idx_q, idx_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d;
    logic [SETTLE_W-1:0]       scnt_q, scnt_d;
    logic [3:0]                l_q, l_d;
    logic [15:0]               ncnt_q, ncnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [31:0]               res_i_q, res_i_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
`ifdef LOCKIN_SWEEP_QUAD_EN
    logic [23:0]               poff_base_q, poff_base_d;
    logic [31:0]               res_q_q, res_q_d;
`endif

    logic signed [ACC_W-1:0]   mix_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [31:0]               mean;
    logic [15:0]               navg_last;
    logic                      last_sample;
    logic [NPTS_W-1:0]         idx_inc;

    always_comb begin
        mix_ext     = {{(ACC_W-32){mix_in[31]}}, mix_in};
        acc_sum     = acc_q + mix_ext;
        // Mean of 2^L signed 32-bit samples always fits back in 32 bits.
        mean        = 32'(acc_sum >>> l_q);
        navg_last   = (16'd1 << l_q) - 16'd1;
        last_sample = (ncnt_q == navg_last);
        idx_inc     = idx_q + NPTS_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        pinc_d      = pinc_q;
        poff_d      = poff_q;
        step_d      = step_q;
        npts_d      = npts_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        scnt_d      = scnt_q;
        l_d         = l_q;
        ncnt_d      = ncnt_q;
        acc_d       = acc_q;
        res_i_d     = res_i_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
`ifdef LOCKIN_SWEEP_QUAD_EN
        poff_base_d = poff_base_q;
        res_q_d     = res_q_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_in && !abort_in) begin
                    step_d   = pinc_step_in;
                    npts_d   = npts_in;
                    settle_d = settle_in;
                    l_d      = log2_navg_in;
                    idx_d    = '0;
`ifdef LOCKIN_SWEEP_QUAD_EN
                    poff_base_d = poff_in;
`endif
                    if (npts_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pinc_d  = pinc_start_in;
                        poff_d  = poff_in;
                        scnt_d  = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            // First SETTLE cycle doubles as the program cycle, so it lasts settle+1.
            S_SETTLE: begin
                if (scnt_q == settle_q) begin
                    acc_d   = '0;
                    ncnt_d  = '0;
                    state_d = S_INTEG;
                end else begin
                    scnt_d = scnt_q + SETTLE_W'(1);
                end
            end
            S_INTEG: begin
                acc_d  = acc_sum;
                ncnt_d = ncnt_q + 16'd1;
                if (last_sample) begin
                    res_i_d = mean;
`ifdef LOCKIN_SWEEP_QUAD_EN
                    poff_d = poff_base_q + 24'h400000;
                    acc_d  = '0;
                    ncnt_d = '0;
                    if (settle_q == '0) begin
                        state_d = S_INTEG_Q;
                    end else begin
                        scnt_d  = SETTLE_W'(1);
                        state_d = S_SETTLE_Q;
                    end
`else
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
`endif
                end
            end
`ifdef LOCKIN_SWEEP_QUAD_EN
            S_SETTLE_Q: begin
                if (scnt_q == settle_q) begin
                    acc_d   = '0;
                    ncnt_d  = '0;
                    state_d = S_INTEG_Q;
                end else begin
                    scnt_d = scnt_q + SETTLE_W'(1);
                end
            end
            S_INTEG_Q: begin
                acc_d  = acc_sum;
                ncnt_d = ncnt_q + 16'd1;
                if (last_sample) begin
                    res_q_d = mean;
                    poff_d  = poff_base_q;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
`endif
            S_OUTPUT: begin
                if (result_ready_in) begin
                    valid_d = 1'b0;
                    if (idx_inc == npts_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        pinc_d  = pinc_q + step_q;
                        scnt_d  = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort outranks everything, including a same-cycle handshake.
        if (abort_in && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            pinc_d  = pinc_q;
            poff_d  = poff_q;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            pinc_q      <= '0;
            poff_q      <= '0;
            step_q      <= '0;
            npts_q      <= '0;
            idx_q       <= '0;
            settle_q    <= '0;
            scnt_q      <= '0;
            l_q         <= '0;
            ncnt_q      <= '0;
            acc_q       <= '0;
            res_i_q     <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef LOCKIN_SWEEP_QUAD_EN
            poff_base_q <= '0;
            res_q_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pinc_q      <= pinc_d;
            poff_q      <= poff_d;
            step_q      <= step_d;
            npts_q      <= npts_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            scnt_q      <= scnt_d;
            l_q         <= l_d;
            ncnt_q      <= ncnt_d;
            acc_q       <= acc_d;
            res_i_q     <= res_i_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
`ifdef LOCKIN_SWEEP_QUAD_EN
            poff_base_q <= poff_base_d;
            res_q_q     <= res_q_d;
`endif
        end
    end

    assign pinc_out         = pinc_q;
    assign poff_out         = poff_q;
    assign result_out       = res_i_q;
`ifdef LOCKIN_SWEEP_QUAD_EN
    assign result_q_out     = res_q_q;
`else
    assign result_q_out     = '0;
`endif
    assign result_idx_out   = idx_q;
    assign result_valid_out = valid_q;
    assign busy_out         = (state_q != S_IDLE);
    assign done_out         = done_q;

endmodule

// File: tb/tb_lockin_sweep_ctrl.sv
// Directed bench for lockin_sweep_ctrl: hand-computed results, latencies, backpressure, wrap, abort and reset cases.
module tb_lockin_sweep_ctrl;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               start_in = 1'b0;
    logic               abort_in = 1'b0;
    logic        [23:0] pinc_start_in = '0;
    logic signed [23:0] pinc_step_in = '0;
    logic        [11:0] npts_in = '0;
    logic        [15:0] settle_in = '0;
    logic        [3:0]  log2_navg_in = '0;
    logic signed [23:0] poff_in = '0;
    logic signed [31:0] mix_in = '0;
    logic        [23:0] pinc_out;
    logic signed [23:0] poff_out;
    logic signed [31:0] result_out;
    logic signed [31:0] result_q_out;
    logic        [11:0] result_idx_out;
    logic               result_valid_out;
    logic               result_ready_in = 1'b1;
    logic               busy_out;
    logic               done_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic alt_mode = 1'b0;
    logic alt_ph   = 1'b0;

    lockin_sweep_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
        .pinc_start_in(pinc_start_in), .pinc_step_in(pinc_step_in), .npts_in(npts_in),
        .settle_in(settle_in), .log2_navg_in(log2_navg_in), .poff_in(poff_in), .mix_in(mix_in),
        .pinc_out(pinc_out), .poff_out(poff_out), .result_out(result_out),
        .result_q_out(result_q_out), .result_idx_out(result_idx_out),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (alt_mode) begin
            alt_ph = ~alt_ph;
            mix_in = alt_ph ? 32'sd5 : -32'sd7;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_wait(input int se, input int l);
        int w;
        w = se + 1 + (1 << l);
`ifdef LOCKIN_SWEEP_QUAD_EN
        w = w + se + (1 << l);
`endif
        return w;
    endfunction

    task automatic start_sweep(input logic [23:0] ps, input logic [23:0] st, input logic [11:0] np,
                               input logic [15:0] se, input logic [3:0] l, input logic [23:0] po);
        pinc_start_in = ps;
        pinc_step_in  = st;
        npts_in       = np;
        settle_in     = se;
        log2_navg_in  = l;
        poff_in       = po;
        start_in      = 1'b1;
        tick();
        start_in      = 1'b0;
        // Scramble config afterwards: the sweep must run on the latched copy.
        pinc_start_in = 24'h5A5A5A;
        pinc_step_in  = 24'h111111;
        npts_in       = 12'd0;
        settle_in     = 16'd7;
        log2_navg_in  = 4'd9;
        poff_in       = 24'h0F0F0F;
    endtask

    task automatic wait_valid(output int n, input int bound);
        n = 0;
        while (!result_valid_out && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        logic ok;

        // Reset state
        tick(); tick();
        check("rst_pinc", pinc_out, 0);
        check("rst_poff", poff_out, 0);
        check("rst_res", result_out, 0);
        check("rst_resq", result_q_out, 0);
        check("rst_idx", result_idx_out, 0);
        check("rst_valid", result_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        rst_in = 1'b1;
        tick();

        // Main sweep: 3 points, const 1000
        mix_in = 32'sd1000;
        result_ready_in = 1'b1;
        start_sweep(24'h000100, 24'h000010, 12'd3, 16'd4, 4'd2, 24'h123456);
        check("main_busy", busy_out, 1);
        check("main_poff", poff_out, 32'h123456);
        for (int p = 0; p < 3; p++) begin
            wait_valid(n, 200);
            check("main_wait", n, exp_wait(4, 2));
            check("main_res", result_out, 32'd1000);
            check("main_idx", result_idx_out, p);
            check("main_pinc", pinc_out, 32'h100 + 32'h10 * p);
            check("main_done_early", done_out, 0);
            tick();
        end
        check("main_done", done_out, 1);
        check("main_idle", busy_out, 0);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid_out || done_out) ok = 1'b0;
        end
        check("main_quiet_after", ok, 1);

        // Alternating -7/+5, L=3 -> -1
        alt_mode = 1'b1;
        start_sweep(24'h000200, 24'h0, 12'd1, 16'd0, 4'd3, 24'h0);
        wait_valid(n, 200);
        check("alt_res", result_out, 32'hFFFF_FFFF);
        tick();
        check("alt_done", done_out, 1);
        alt_mode = 1'b0;

        // Full-scale negative, L=15
        mix_in = 32'sh8000_0000;
        start_sweep(24'h000300, 24'h0, 12'd1, 16'd0, 4'd15, 24'h0);
        wait_valid(n, 40000);
        check("big_wait", n, exp_wait(0, 15));
        check("big_res", result_out, 32'h8000_0000);
        tick();

        // Backpressure
        mix_in = 32'sd42;
        result_ready_in = 1'b0;
        start_sweep(24'h000200, 24'h000008, 12'd2, 16'd1, 4'd1, 24'h0);
        wait_valid(n, 200);
        check("bp_wait", n, exp_wait(1, 1));
        mix_in = 32'sd99;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!result_valid_out || result_out != 32'sd42 || result_idx_out != 12'd0
                || pinc_out != 24'h000200) ok = 1'b0;
        end
        check("bp_stable", ok, 1);
        result_ready_in = 1'b1;
        tick();
        check("bp_pinc_next", pinc_out, 32'h000208);
        check("bp_valid_drop", result_valid_out, 0);
        wait_valid(n, 200);
        check("bp_res2", result_out, 32'd99);
        check("bp_idx2", result_idx_out, 1);
        tick();
        check("bp_done", done_out, 1);

        // pinc wrap
        start_sweep(24'hFFFFF0, 24'h000020, 12'd2, 16'd0, 4'd0, 24'h0);
        check("wrap_pinc0", pinc_out, 32'hFFFFF0);
        wait_valid(n, 200);
        tick();
        check("wrap_pinc1", pinc_out, 32'h000010);
        wait_valid(n, 200);
        check("wrap_idx1", result_idx_out, 1);
        tick();
        check("wrap_done", done_out, 1);

        // npts = 0
        start_sweep(24'h000100, 24'h0, 12'd0, 16'd3, 4'd2, 24'h0);
        check("n0_done", done_out, 1);
        check("n0_busy", busy_out, 0);
        check("n0_valid", result_valid_out, 0);
        tick();
        check("n0_done_pulse", done_out, 0);

        // Abort in SETTLE
        start_sweep(24'h000400, 24'h0, 12'd2, 16'd10, 4'd2, 24'h0);
        tick(); tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("ab_set_busy", busy_out, 0);
        check("ab_set_done", done_out, 0);
        check("ab_set_pinc", pinc_out, 32'h000400);

        // Abort in INTEG
        start_sweep(24'h000500, 24'h0, 12'd2, 16'd0, 4'd4, 24'h0);
        tick(); tick(); tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("ab_int_busy", busy_out, 0);
        check("ab_int_valid", result_valid_out, 0);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid_out || done_out) ok = 1'b0;
        end
        check("ab_int_quiet", ok, 1);

        // Abort coincident with handshake
        start_sweep(24'h000600, 24'h000040, 12'd2, 16'd1, 4'd1, 24'h0);
        wait_valid(n, 200);
        result_ready_in = 1'b1;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("ab_hs_busy", busy_out, 0);
        check("ab_hs_valid", result_valid_out, 0);
        check("ab_hs_done", done_out, 0);
        check("ab_hs_pinc", pinc_out, 32'h000600);

        // start together with abort in IDLE
        pinc_start_in = 24'h000700;
        npts_in = 12'd1;
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        check("sa_busy", busy_out, 0);
        check("sa_pinc", pinc_out, 32'h000600);

        // Reset mid-INTEG, then a clean sweep
        mix_in = 32'sd1000;
        start_sweep(24'h000800, 24'h0, 12'd2, 16'd0, 4'd4, 24'h654321);
        tick(); tick(); tick();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        check("mrst_pinc", pinc_out, 0);
        check("mrst_poff", poff_out, 0);
        check("mrst_busy", busy_out, 0);
        check("mrst_valid", result_valid_out, 0);
        check("mrst_res", result_out, 0);
        check("mrst_done", done_out, 0);
        start_sweep(24'h000900, 24'h0, 12'd1, 16'd2, 4'd2, 24'h0);
        wait_valid(n, 200);
        check("mrst_wait", n, exp_wait(2, 2));
        check("mrst_res2", result_out, 32'd1000);
        tick();
        check("mrst_done2", done_out, 1);

        // Quadrature offset / disabled-Q behaviour
        mix_in = 32'sd77;
        start_sweep(24'h000A00, 24'h0, 12'd1, 16'd2, 4'd1, 24'hE00000);
`ifdef LOCKIN_SWEEP_QUAD_EN
        n = 0;
        while (poff_out != 24'h200000 && n < 50) begin
            tick();
            n++;
        end
        check("q_poff90", poff_out, 32'h200000);
        wait_valid(n, 200);
        check("q_poff_restore", poff_out, 32'hE00000);
        check("q_resq", result_q_out, 32'd77);
`else
        ok = 1'b1;
        n = 0;
        while (!result_valid_out && n < 200) begin
            if (poff_out != 24'hE00000) ok = 1'b0;
            tick();
            n++;
        end
        check("q_poff_const", ok, 1);
        check("q_resq_zero", result_q_out, 0);
`endif
        check("q_resi", result_out, 32'd77);
        tick();
        check("q_done", done_out, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lockin_sweep_ctrl.md
Name: lockin_sweep_ctrl

Overview:
- Sequencer that drives the lock-in LO through a frequency sweep.
- For each point it:
  - programs the LO phase increment and phase offset;
  - waits a programmable settling time to cover DDS, mixer and filter latency;
  - integrates the 32-bit mixer/filter output over 2^L samples;
  - emits the averaged result over a valid/ready handshake.
- Sits between the host configuration registers and the lock-in datapath. Owns pinc/poff while a sweep is running.

Parameters:
- ACC_W, 48, accumulator width. Must be at least 32+15.
- NPTS_W, 12, width of point count and point index.
- SETTLE_W, 16, width of settle counter.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- start_in  in  1  start sweep. Sampled only in IDLE.
- abort_in  in  1  abort sweep. Honoured in any state.
- pinc_start_in  in  24  phase increment of point 0
- pinc_step_in  in  24 signed  per-point increment delta
- npts_in  in  NPTS_W  number of points
- settle_in  in  SETTLE_W  settle cycles per point
- log2_navg_in  in  4  L, giving 2^L samples per point
- poff_in  in  24 signed  base phase offset
- mix_in  in  32 signed  lock-in mixer/filter output
- pinc_out  out  24  LO phase increment to datapath
- poff_out  out  24 signed  LO phase offset to datapath
- result_out  out  32 signed  averaged in-phase result
- result_q_out  out  32 signed  averaged quadrature result. Zero without the optional feature.
- result_idx_out  out  NPTS_W  point index of the current result
- result_valid_out  out  1  result valid
- result_ready_in  in  1  consumer ready
- busy_out  out  1  high in any state other than IDLE
- done_out  out  1  one-cycle pulse when a sweep completes normally

Behaviour:
- Reset (rst_in=0 at a clock edge) forces:
  - state IDLE;
  - all outputs 0, including pinc_out, poff_out, result_out, result_q_out, result_idx_out, result_valid_out, busy_out and done_out.
- Reset asserted mid-sweep has the same effect.
- States: IDLE, SETTLE, INTEG, [SETTLE_Q, INTEG_Q], OUTPUT.
- IDLE:
  - On start_in=1, latch all configuration inputs and set index to 0.
  - If npts_in=0: pulse done_out the next cycle and remain in IDLE.
  - Otherwise: set pinc_out=pinc_start_in, poff_out=poff_in, and go to SETTLE.
- Configuration inputs are ignored while busy.
- SETTLE:
  - Counts settle_in cycles, then enters INTEG.
  - settle_in=0 enters INTEG on the cycle after entry to SETTLE.
- INTEG:
  - Clears the accumulator on entry.
  - Adds sign-extended mix_in every cycle for exactly 2^L cycles.
  - Then result = acc >>> L (arithmetic shift), truncated to 32 bits. This is exact, since the mean of signed 32-bit values fits in 32 bits.
- OUTPUT:
  - result_valid_out=1, with result_out, result_q_out and result_idx_out held stable until result_valid_out && result_ready_in.
  - pinc_out is held during backpressure.
  - On the handshake:
    - If idx=npts-1: drop valid, go to IDLE and pulse done_out in the same cycle the state becomes IDLE.
    - Otherwise: idx+1, pinc_out += pinc_step_in (modulo 2^24, wraps silently), go to SETTLE.
- Abort:
  - abort_in=1 in any non-IDLE state goes to IDLE at the next edge.
  - Clears result_valid_out. No done_out pulse.
  - pinc_out and poff_out keep their last values.
- Abort has priority over the handshake in the same cycle.
- start_in together with abort_in in IDLE: abort wins and the sweep does not start.
- Per-point latency, with no backpressure and no Q phase: 1 (program) + settle_in + 2^L + 1 (OUTPUT) cycles.

Optional Feature:
- Macro LOCKIN_SWEEP_QUAD_EN.
- When defined:
  - After INTEG, set poff_out = poff_base + 24'h400000 (+90 deg, modulo 2^24).
  - Run SETTLE_Q (settle_in cycles), then INTEG_Q (2^L samples) into result_q_out.
  - Restore poff_out = poff_base on entering OUTPUT.
  - Per-point latency adds settle_in + 2^L cycles.
- When undefined:
  - SETTLE_Q and INTEG_Q do not exist.
  - result_q_out is constant 0.
  - poff_out stays at poff_in for the whole sweep.

Test Plan:
- Reset mid-INTEG, rst_in=0 for 1 cycle -> next cycle all outputs 0, busy_out=0. start_in then begins a clean sweep.
- npts=3, pinc_start=24'h000100, step=24'h000010, settle=4, L=2, mix_in=const 1000, ready always high -> pinc_out sequence 0x100/0x110/0x120; results 1000 at idx 0,1,2; exactly 3 valids; done_out pulses once, 1+4+4+1 cycles after each point is programmed.
- mix_in alternating -7,+5 with L=3 -> result_out=-1 (sum -8 >>> 3). mix_in = -2^31 constant with L=15 -> result = -2^31 with no overflow.
- ready held low 20 cycles in OUTPUT -> valid, result and idx stable; pinc_out unchanged; no sample lost when ready rises.
- pinc_start=24'hFFFFF0, step=24'h000020, npts=2 -> second pinc_out = 24'h000010 (wrap). npts=0 -> done_out one cycle after start, no valid.
- abort_in pulsed in SETTLE, in INTEG, and coincident with a handshake -> IDLE next cycle, valid=0, no done_out. With LOCKIN_SWEEP_QUAD_EN and poff_in=24'hE00000: Q phase sees poff_out=24'h200000.
